// File: rtl/renode_ahb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : renode_ahb_arbiter
// Brief    : Round-robin AHB-Lite interconnect stage sharing one subordinate
//            port between NumManagers managers. Losing managers have their
//            address phase captured in a pending register and are stalled
//            through their own hready. SEQ beats keep the grant with the
//            current owner.
// Options  : define RENODE_AHB_ARBITER_LOCK_EN to add m_hmastlock/s_hmastlock
//            and locked-sequence arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module renode_ahb_arbiter #(
  parameter int NumManagers  = 2,
  parameter int AddressWidth = 32,
  parameter int DataWidth    = 32
) (
  input  logic                              hclk,
  input  logic                              hresetn,
  input  logic [2*NumManagers-1:0]          m_htrans,
  input  logic [AddressWidth*NumManagers-1:0] m_haddr,
  input  logic [NumManagers-1:0]            m_hwrite,
  input  logic [3*NumManagers-1:0]          m_hsize,
  input  logic [DataWidth*NumManagers-1:0]  m_hwdata,
`ifdef RENODE_AHB_ARBITER_LOCK_EN
  input  logic [NumManagers-1:0]            m_hmastlock,
  output logic                              s_hmastlock,
`endif
  output logic [NumManagers-1:0]            m_hready,
  output logic [NumManagers-1:0]            m_hresp,
  output logic [DataWidth-1:0]              m_hrdata,
  output logic [1:0]                        s_htrans,
  output logic [AddressWidth-1:0]           s_haddr,
  output logic                              s_hwrite,
  output logic [2:0]                        s_hsize,
  output logic [DataWidth-1:0]              s_hwdata,
  output logic                              s_hready,
  input  logic                              s_hreadyout,
  input  logic                              s_hresp,
  input  logic [DataWidth-1:0]              s_hrdata
);

  localparam int               IDX_W       = $clog2(NumManagers);
  localparam logic [IDX_W:0]   NUM_M       = (IDX_W+1)'(NumManagers);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NumManagers - 1);
  localparam logic [1:0]       TRANS_IDLE  = 2'd0;
  localparam logic [1:0]       TRANS_NSEQ  = 2'd2;
  localparam logic [1:0]       TRANS_SEQ   = 2'd3;

  // Per-manager views of the flattened input buses
  logic [1:0]              htrans_a [NumManagers];
  logic [AddressWidth-1:0] addr_a   [NumManagers];
  logic [2:0]              size_a   [NumManagers];
  logic [DataWidth-1:0]    wdata_a  [NumManagers];

  // Pending address-phase capture
  logic [NumManagers-1:0]  pending;
  logic [AddressWidth-1:0] pend_addr [NumManagers];
  logic [NumManagers-1:0]  pend_write;
  logic [2:0]              pend_size [NumManagers];

  // Data-phase tracking and arbitration state
  logic                    data_valid;
  logic [IDX_W-1:0]        data_owner;
  logic [IDX_W-1:0]        rr_last;

  logic [NumManagers-1:0]  live;
  logic [NumManagers-1:0]  cand;
  logic [NumManagers-1:0]  owner_match;
  logic                    hold;
  logic                    grant_valid;
  logic [IDX_W-1:0]        grant;
  logic [IDX_W:0]          rr_sum;
  logic                    forward;

`ifdef RENODE_AHB_ARBITER_LOCK_EN
  logic                    locked;
  logic [NumManagers-1:0]  pend_lock;
  logic                    sel_lock;
`endif

  for (genvar i = 0; i < NumManagers; i++) begin : g_mgr
    assign htrans_a[i]    = m_htrans[2*i +: 2];
    assign addr_a[i]      = m_haddr[AddressWidth*i +: AddressWidth];
    assign size_a[i]      = m_hsize[3*i +: 3];
    assign wdata_a[i]     = m_hwdata[DataWidth*i +: DataWidth];
    assign owner_match[i] = data_valid && (data_owner == IDX_W'(i));
    // NonSeq and Seq both have bit 1 set; Idle and Busy never request
    assign live[i]        = htrans_a[i][1] && m_hready[i];
    assign cand[i]        = pending[i] || live[i];
    // The data-phase owner sees the subordinate; a captured manager stalls
    assign m_hready[i]    = owner_match[i] ? s_hreadyout : !pending[i];
    assign m_hresp[i]     = owner_match[i] ? s_hresp : 1'b0;
  end

  assign hold     = live[rr_last] && (htrans_a[rr_last] == TRANS_SEQ);
  assign forward  = s_hreadyout && grant_valid;
  assign s_hready = s_hreadyout;
  assign s_hwdata = wdata_a[data_owner];
  assign m_hrdata = s_hrdata;

  // Grant selection: burst hold, else first candidate after rr_last
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    rr_sum      = '0;
    if (hold) begin
      grant_valid = 1'b1;
      grant       = rr_last;
    end else begin
      for (int k = 1; k <= NumManagers; k++) begin
        rr_sum = {1'b0, rr_last} + (IDX_W+1)'(k);
        if (rr_sum >= NUM_M) begin
          rr_sum = rr_sum - NUM_M;
        end
        if (!grant_valid && cand[rr_sum[IDX_W-1:0]]) begin
          grant_valid = 1'b1;
          grant       = rr_sum[IDX_W-1:0];
        end
      end
    end
`ifdef RENODE_AHB_ARBITER_LOCK_EN
    // A locked sequence admits only the lock holder (last forwarded manager)
    if (locked) begin
      grant_valid = cand[rr_last];
      grant       = rr_last;
    end
`endif
    // Nothing is presented to the subordinate while reset is asserted
    if (!hresetn) begin
      grant_valid = 1'b0;
    end
  end

  // Address-phase mux: captured transfer replays as NonSeq, live one passes through
  always_comb begin
    s_htrans = TRANS_IDLE;
    s_haddr  = '0;
    s_hwrite = 1'b0;
    s_hsize  = '0;
`ifdef RENODE_AHB_ARBITER_LOCK_EN
    sel_lock    = 1'b0;
    s_hmastlock = 1'b0;
`endif
    if (grant_valid) begin
      if (pending[grant]) begin
        s_htrans = TRANS_NSEQ;
        s_haddr  = pend_addr[grant];
        s_hwrite = pend_write[grant];
        s_hsize  = pend_size[grant];
`ifdef RENODE_AHB_ARBITER_LOCK_EN
        sel_lock = pend_lock[grant];
`endif
      end else begin
        s_htrans = htrans_a[grant];
        s_haddr  = addr_a[grant];
        s_hwrite = m_hwrite[grant];
        s_hsize  = size_a[grant];
`ifdef RENODE_AHB_ARBITER_LOCK_EN
        sel_lock = m_hmastlock[grant];
`endif
      end
`ifdef RENODE_AHB_ARBITER_LOCK_EN
      s_hmastlock = sel_lock;
`endif
    end
  end

  // Capture accepted-but-not-forwarded address phases; release on forward
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      pending    <= '0;
      pend_write <= '0;
      for (int i = 0; i < NumManagers; i++) begin
        pend_addr[i] <= '0;
        pend_size[i] <= '0;
      end
`ifdef RENODE_AHB_ARBITER_LOCK_EN
      pend_lock <= '0;
`endif
    end else begin
      for (int i = 0; i < NumManagers; i++) begin
        if (forward && (grant == IDX_W'(i))) begin
          pending[i] <= 1'b0;
        end else if (live[i]) begin
          pending[i]    <= 1'b1;
          pend_addr[i]  <= addr_a[i];
          pend_write[i] <= m_hwrite[i];
          pend_size[i]  <= size_a[i];
`ifdef RENODE_AHB_ARBITER_LOCK_EN
          pend_lock[i]  <= m_hmastlock[i];
`endif
        end
      end
    end
  end

  // Data-phase owner and round-robin pointer advance on ready edges
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      data_valid <= 1'b0;
      data_owner <= '0;
      rr_last    <= LAST_IDX;
    end else if (s_hreadyout) begin
      data_valid <= grant_valid;
      if (grant_valid) begin
        data_owner <= grant;
        rr_last    <= grant;
      end
    end
  end

`ifdef RENODE_AHB_ARBITER_LOCK_EN
  // Lock follows each forwarded transfer; an unlocked Idle also releases it
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      locked <= 1'b0;
    end else if (forward) begin
      locked <= sel_lock;
    end else if (locked && s_hreadyout && (htrans_a[rr_last] == TRANS_IDLE)
                 && !m_hmastlock[rr_last]) begin
      locked <= 1'b0;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_renode_ahb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_renode_ahb_arbiter
// Brief    : Directed self-checking bench for renode_ahb_arbiter with two
//            managers; covers single transfer, contention, burst hold, wait
//            states, error response, mid-transfer reset and (when
//            RENODE_AHB_ARBITER_LOCK_EN is defined) locked sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_renode_ahb_arbiter;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [3:0]  m_htrans;
  logic [63:0] m_haddr;
  logic [1:0]  m_hwrite;
  logic [5:0]  m_hsize;
  logic [63:0] m_hwdata;
  logic [1:0]  m_hready;
  logic [1:0]  m_hresp;
  logic [31:0] m_hrdata;
  logic [1:0]  s_htrans;
  logic [31:0] s_haddr;
  logic        s_hwrite;
  logic [2:0]  s_hsize;
  logic [31:0] s_hwdata;
  logic        s_hready;
  logic        s_hreadyout;
  logic        s_hresp;
  logic [31:0] s_hrdata;
`ifdef RENODE_AHB_ARBITER_LOCK_EN
  logic [1:0]  m_hmastlock;
  logic        s_hmastlock;
`endif

  int tests;
  int failed;

  renode_ahb_arbiter #(
    .NumManagers (2),
    .AddressWidth(32),
    .DataWidth   (32)
  ) dut (
    .hclk       (hclk),
    .hresetn    (hresetn),
    .m_htrans   (m_htrans),
    .m_haddr    (m_haddr),
    .m_hwrite   (m_hwrite),
    .m_hsize    (m_hsize),
    .m_hwdata   (m_hwdata),
`ifdef RENODE_AHB_ARBITER_LOCK_EN
    .m_hmastlock(m_hmastlock),
    .s_hmastlock(s_hmastlock),
`endif
    .m_hready   (m_hready),
    .m_hresp    (m_hresp),
    .m_hrdata   (m_hrdata),
    .s_htrans   (s_htrans),
    .s_haddr    (s_haddr),
    .s_hwrite   (s_hwrite),
    .s_hsize    (s_hsize),
    .s_hwdata   (s_hwdata),
    .s_hready   (s_hready),
    .s_hreadyout(s_hreadyout),
    .s_hresp    (s_hresp),
    .s_hrdata   (s_hrdata)
  );

  // Free-running bus clock
  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drv(input logic idx, input logic [1:0] t, input logic [31:0] a,
                     input logic w);
    if (idx) begin
      m_htrans[3:2]  = t;
      m_haddr[63:32] = a;
      m_hwrite[1]    = w;
      m_hsize[5:3]   = 3'd2;
    end else begin
      m_htrans[1:0]  = t;
      m_haddr[31:0]  = a;
      m_hwrite[0]    = w;
      m_hsize[2:0]   = 3'd2;
    end
  endtask

  initial begin
    tests       = 0;
    failed      = 0;
    hresetn     = 1'b0;
    m_htrans    = '0;
    m_haddr     = '0;
    m_hwrite    = '0;
    m_hsize     = '0;
    m_hwdata    = '0;
    s_hreadyout = 1'b1;
    s_hresp     = 1'b0;
    s_hrdata    = '0;
`ifdef RENODE_AHB_ARBITER_LOCK_EN
    m_hmastlock = '0;
`endif
    #2;
    chk("rst_hready", 32'(m_hready), 32'h3);
    chk("rst_hresp",  32'(m_hresp),  32'h0);
    chk("rst_htrans", 32'(s_htrans), 32'h0);
    chk("rst_haddr",  s_haddr,       32'h0);
    chk("rst_hwrite", 32'(s_hwrite), 32'h0);
    chk("rst_hsize",  32'(s_hsize),  32'h0);
    step();
    hresetn = 1'b1;

    // Single manager write, zero-wait subordinate
    drv(1'b0, 2'd2, 32'h1000, 1'b1);
    settle();
    chk("t1_htrans", 32'(s_htrans), 32'h2);
    chk("t1_haddr",  s_haddr,       32'h1000);
    chk("t1_hwrite", 32'(s_hwrite), 32'h1);
    chk("t1_hready", 32'(m_hready), 32'h3);
    step();
    drv(1'b0, 2'd0, 32'h0, 1'b0);
    m_hwdata[31:0] = 32'hDEADBEEF;
    settle();
    chk("t1_hwdata",  s_hwdata,      32'hDEADBEEF);
    chk("t1_hready2", 32'(m_hready), 32'h3);
    chk("t1_sready",  32'(s_hready), 32'h1);
    chk("t1_idle",    32'(s_htrans), 32'h0);
    step();

    // Reset so manager 0 regains first priority
    hresetn = 1'b0;
    step();
    hresetn = 1'b1;

    // Contention: both managers read in the same cycle
    drv(1'b0, 2'd2, 32'h10, 1'b0);
    drv(1'b1, 2'd2, 32'h20, 1'b0);
    settle();
    chk("t2_haddr0", s_haddr,       32'h10);
    chk("t2_hready", 32'(m_hready), 32'h3);
    step();
    drv(1'b0, 2'd0, 32'h0, 1'b0);
    drv(1'b1, 2'd0, 32'h0, 1'b0);
    s_hrdata = 32'hA;
    settle();
    chk("t2_hready_p", 32'(m_hready), 32'h1);
    chk("t2_rdata0",   m_hrdata,      32'hA);
    chk("t2_htrans1",  32'(s_htrans), 32'h2);
    chk("t2_haddr1",   s_haddr,       32'h20);
    step();
    s_hrdata = 32'hB;
    settle();
    chk("t2_hready1", 32'(m_hready), 32'h3);
    chk("t2_rdata1",  m_hrdata,      32'hB);
    chk("t2_idle",    32'(s_htrans), 32'h0);
    step();

    // Burst hold: manager 1 four-beat burst, manager 0 requests on beat 1
    drv(1'b1, 2'd2, 32'h100, 1'b0);
    settle();
    chk("t3_b0", s_haddr, 32'h100);
    step();
    drv(1'b1, 2'd3, 32'h104, 1'b0);
    drv(1'b0, 2'd2, 32'h200, 1'b1);
    settle();
    chk("t3_b1",      s_haddr,       32'h104);
    chk("t3_b1_seq",  32'(s_htrans), 32'h3);
    chk("t3_b1_rdy",  32'(m_hready), 32'h3);
    step();
    drv(1'b1, 2'd3, 32'h108, 1'b0);
    drv(1'b0, 2'd0, 32'h0, 1'b0);
    settle();
    chk("t3_b2",     s_haddr,       32'h108);
    chk("t3_b2_rdy", 32'(m_hready), 32'h2);
    step();
    drv(1'b1, 2'd3, 32'h10C, 1'b0);
    settle();
    chk("t3_b3",     s_haddr,       32'h10C);
    chk("t3_b3_rdy", 32'(m_hready), 32'h2);
    step();
    drv(1'b1, 2'd0, 32'h0, 1'b0);
    settle();
    chk("t3_m0_trans", 32'(s_htrans), 32'h2);
    chk("t3_m0_addr",  s_haddr,       32'h200);
    chk("t3_m0_write", 32'(s_hwrite), 32'h1);
    step();
    settle();
    chk("t3_done_rdy", 32'(m_hready), 32'h3);
    step();

    // Wait states on manager 0 read while manager 1 requests
    drv(1'b0, 2'd2, 32'h300, 1'b0);
    settle();
    chk("t4_addr0", s_haddr, 32'h300);
    step();
    drv(1'b0, 2'd0, 32'h0, 1'b0);
    drv(1'b1, 2'd2, 32'h400, 1'b0);
    s_hreadyout = 1'b0;
    settle();
    chk("t4_w1_rdy",  32'(m_hready), 32'h2);
    chk("t4_w1_addr", s_haddr,       32'h400);
    step();
    drv(1'b1, 2'd0, 32'h0, 1'b0);
    settle();
    chk("t4_w2_rdy",  32'(m_hready), 32'h0);
    chk("t4_w2_addr", s_haddr,       32'h400);
    step();
    settle();
    chk("t4_w3_rdy",  32'(m_hready), 32'h0);
    chk("t4_w3_addr", s_haddr,       32'h400);
    step();
    s_hreadyout = 1'b1;
    s_hrdata    = 32'hC;
    settle();
    chk("t4_end_rdy",  32'(m_hready), 32'h1);
    chk("t4_end_data", m_hrdata,      32'hC);
    chk("t4_end_addr", s_haddr,       32'h400);
    chk("t4_end_tr",   32'(s_htrans), 32'h2);
    step();

    // Two-cycle error to manager 1; manager 0 captured meanwhile
    s_hreadyout = 1'b0;
    s_hresp     = 1'b1;
    drv(1'b0, 2'd2, 32'h500, 1'b0);
    settle();
    chk("t5_e1_resp", 32'(m_hresp),  32'h2);
    chk("t5_e1_rdy",  32'(m_hready), 32'h1);
    step();
    s_hreadyout = 1'b1;
    drv(1'b0, 2'd0, 32'h0, 1'b0);
    settle();
    chk("t5_e2_resp", 32'(m_hresp),  32'h2);
    chk("t5_e2_rdy",  32'(m_hready), 32'h2);
    chk("t5_e2_addr", s_haddr,       32'h500);
    chk("t5_e2_tr",   32'(s_htrans), 32'h2);
    step();
    s_hresp = 1'b0;
    settle();
    chk("t5_ok_resp", 32'(m_hresp),  32'h0);
    chk("t5_ok_rdy",  32'(m_hready), 32'h3);
    step();

    // Reset asserted mid data phase
    drv(1'b0, 2'd2, 32'h600, 1'b0);
    step();
    drv(1'b0, 2'd2, 32'h604, 1'b0);
    s_hreadyout = 1'b0;
    settle();
    chk("t6_stall", 32'(m_hready), 32'h2);
    hresetn = 1'b0;
    settle();
    chk("t6_rst_rdy", 32'(m_hready), 32'h3);
    chk("t6_rst_tr",  32'(s_htrans), 32'h0);
    chk("t6_rst_rsp", 32'(m_hresp),  32'h0);
    drv(1'b0, 2'd0, 32'h0, 1'b0);
    s_hreadyout = 1'b1;
    step();
    hresetn = 1'b1;
    step();

`ifdef RENODE_AHB_ARBITER_LOCK_EN
    // Locked pair from manager 0 holds off pending manager 1
    drv(1'b0, 2'd2, 32'h700, 1'b0);
    m_hmastlock = 2'b01;
    settle();
    chk("t7_l0_addr", s_haddr,          32'h700);
    chk("t7_l0_lock", 32'(s_hmastlock), 32'h1);
    step();
    drv(1'b0, 2'd2, 32'h704, 1'b1);
    drv(1'b1, 2'd2, 32'h800, 1'b0);
    settle();
    chk("t7_l1_addr", s_haddr, 32'h704);
    step();
    drv(1'b0, 2'd0, 32'h0, 1'b0);
    drv(1'b1, 2'd0, 32'h0, 1'b0);
    settle();
    chk("t7_hold_tr",  32'(s_htrans), 32'h0);
    chk("t7_hold_rdy", 32'(m_hready[1]), 32'h0);
    step();
    m_hmastlock = 2'b00;
    settle();
    chk("t7_still_locked", 32'(s_htrans), 32'h0);
    step();
    settle();
    chk("t7_rel_tr",   32'(s_htrans),    32'h2);
    chk("t7_rel_addr", s_haddr,          32'h800);
    chk("t7_rel_lock", 32'(s_hmastlock), 32'h0);
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
